regfile_sb: RTL and testbench

// Parametrised multi-read-port integer register file for the RV32I core.

---
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with write bypass, pending-write scoreboard
// and a post-reset clear sweep so the array needs no reset fan-out.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [AW:0] NRegsW = (AW + 1)'(NREGS);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic              clr_en, wr_en, iss_en;
  logic [AW-1:0]     rsel;

  // x0 and addresses beyond the array are never written, issued or read.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NRegsW);
  endfunction

  assign ready  = (state_q == StRun);
  assign wr_en  = ready & we & addr_ok(waddr);
  assign iss_en = ready & iss_valid & addr_ok(iss_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    if (state_q == StClear) begin
      clr_en = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = StRun;
      end
    end
  end

  // Issue is applied after the write clear so a same-edge new producer stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[waddr] = 1'b0;
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array has no reset so it can map onto RAM; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_en) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    rsel    = '0;
    for (int i = 0; i < NRD; i++) begin
      rsel = ra[i*AW +: AW];
      if (ready && addr_ok(rsel)) begin
        if ((BYPASS != 0) && wr_en && (waddr == rsel)) begin
          rd[i*XLEN +: XLEN] = wdata;
        end else begin
          rd[i*XLEN +: XLEN] = mem_q[rsel];
          rd_busy[i]         = busy_q[rsel];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised checks of regfile_sb: a 32x2 bypassing instance and a
// 16x3 non-bypassing instance driven against a reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NREGS=32, NRD=2, BYPASS=1
  logic        rst_n, ready, we, iss_valid;
  logic [4:0]  waddr, iss_addr;
  logic [31:0] wdata;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;

  // Instance B: NREGS=16, NRD=3, BYPASS=0
  logic        b_rst_n, b_ready, b_we, b_iss_valid;
  logic [3:0]  b_waddr, b_iss_addr;
  logic [31:0] b_wdata;
  logic [11:0] b_ra;
  logic [95:0] b_rd;
  logic [2:0]  b_rd_busy;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
    .ra(ra), .rd(rd), .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .ready(b_ready), .we(b_we), .waddr(b_waddr),
    .wdata(b_wdata), .ra(b_ra), .rd(b_rd), .rd_busy(b_rd_busy),
    .iss_valid(b_iss_valid), .iss_addr(b_iss_addr)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from release until ready, bounded.
  task automatic sweep_a(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    push(32);
    chk(tag, n);
  endtask

  logic [31:0] m_mem [16];
  logic        m_busy [16];

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ra = '0;
    iss_valid = 1'b0; iss_addr = '0;
    b_rst_n = 1'b0; b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_ra = '0;
    b_iss_valid = 1'b0; b_iss_addr = '0;

    // Reset and sweep latency
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    #1;
    push(0); chk("ready_low", ready);
    push(0); chk("b_ready_low", b_ready);
    sweep_a("sweep_len");
    ra = {5'd0, 5'd31};
    #1;
    push(0); chk("clr_rd0", rd[31:0]);
    push(0); chk("clr_rd1", rd[63:32]);
    push(0); chk("clr_busy", rd_busy);

    // Write then read
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra = {5'd0, 5'd5};
    #1;
    push(32'hDEADBEEF); chk("wr5_rd0", rd[31:0]);

    // Write to x0 discarded, not bypassed
    we = 1'b1; waddr = 5'd0; wdata = 32'h1;
    #1;
    push(0); chk("x0_byp", rd[63:32]);
    tick();
    we = 1'b0;
    #1;
    push(0); chk("x0_after", rd[63:32]);

    // Same-cycle bypass on both ports
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234; ra = {5'd7, 5'd7};
    #1;
    push(32'h1234); chk("byp_rd0", rd[31:0]);
    push(32'h1234); chk("byp_rd1", rd[63:32]);
    tick();
    we = 1'b0; wdata = '0;
    #1;
    push(32'h1234); chk("byp_stored", rd[31:0]);

    // Scoreboard
    iss_valid = 1'b1; iss_addr = 5'd9; ra = {5'd0, 5'd9};
    #1;
    push(0); chk("iss_pre", rd_busy[0]);
    tick();
    iss_valid = 1'b0;
    #1;
    push(1); chk("iss_busy", rd_busy[0]);
    push(0); chk("x0_busy", rd_busy[1]);
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    #1;
    push(0); chk("wb_byp_busy", rd_busy[0]);
    push(32'h55); chk("wb_byp_rd", rd[31:0]);
    tick();
    we = 1'b0;
    #1;
    push(0); chk("wb_cleared", rd_busy[0]);
    iss_valid = 1'b1; iss_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h66;
    tick();
    iss_valid = 1'b0; we = 1'b0;
    #1;
    push(1); chk("iss_wins", rd_busy[0]);
    push(32'h66); chk("iss_wr_rd", rd[31:0]);
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    iss_valid = 1'b0;
    #1;
    push(0); chk("iss_x0", rd_busy[1]);

    // Mid-sweep reset, write during sweep lost
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    push(0); chk("rst_ready", ready);
    repeat (5) tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA5555; ra = {5'd9, 5'd3};
    #1;
    push(0); chk("sweep_rd", rd[31:0]);
    push(0); chk("sweep_busy", rd_busy[1]);
    tick();
    we = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep_a("resweep_len");
    ra = {5'd5, 5'd3};
    #1;
    push(0); chk("lost_wr3", rd[31:0]);
    push(0); chk("cleared5", rd[63:32]);
    ra = {5'd0, 5'd9};
    #1;
    push(0); chk("busy_reset", rd_busy[0]);

    // Instance B: random traffic against a model
    push(1); chk("b_ready", b_ready);
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      b_we        = ($urandom_range(0, 1) == 1);
      b_waddr     = 4'($urandom_range(0, 15));
      b_wdata     = $urandom;
      b_iss_valid = ($urandom_range(0, 3) == 0);
      b_iss_addr  = 4'($urandom_range(0, 15));
      // Bias one port toward the read-after-write hazard
      b_ra = {4'($urandom_range(0, 15)), b_waddr, 4'($urandom_range(0, 15))};
      #1;
      for (int p = 0; p < 3; p++) begin
        logic [3:0] a;
        a = b_ra[p*4 +: 4];
        push((a == 4'd0) ? 32'd0 : m_mem[a]);
        chk($sformatf("b_rd%0d_c%0d", p, c), b_rd[p*32 +: 32]);
        push((a == 4'd0) ? 32'd0 : {31'd0, m_busy[a]});
        chk($sformatf("b_busy%0d_c%0d", p, c), {31'd0, b_rd_busy[p]});
      end
      @(posedge clk);
      if (b_we && b_waddr != 4'd0) begin
        m_mem[b_waddr] = b_wdata;
        m_busy[b_waddr] = 1'b0;
      end
      if (b_iss_valid && b_iss_addr != 4'd0) begin
        m_busy[b_iss_addr] = 1'b1;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
